// File: rtl/tblink_rpc_cmd_pkg.sv
// Shared opcode, response-size and scheduler state definitions for the
// tblink RPC control endpoint.
package tblink_rpc_cmd_pkg;

  localparam logic [7:0] CMD_GET_TIME    = 8'd1;
  localparam logic [7:0] CMD_SET_TIMER   = 8'd2;
  localparam logic [7:0] CMD_RELEASE     = 8'd3;
  localparam logic [7:0] CMD_SET_DIVISOR = 8'd4;
  localparam logic [7:0] CMD_HALT        = 8'd5;

  localparam logic [7:0] RSP_SZ_NONE = 8'd0;
  localparam logic [7:0] RSP_SZ_TIME = 8'd8;

  typedef enum logic [1:0] {
    ST_HALTED   = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } sched_state_e;

endpackage

// File: rtl/tblink_rpc_clkdiv.sv
// Programmable divider producing the registered cclock from uclock.
// Half-period is (div+1) uclock cycles; rise/fall strobe in the cycle
// whose closing edge changes cclock. Disabled -> cclock parked low.
module tblink_rpc_clkdiv #(
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             cclock,
  output logic             rise,
  output logic             fall
);

  logic [DIV_W-1:0] div_cnt;
  logic             toggle;

  // >= rather than == so a divisor shrink below the running count
  // toggles on the next cycle instead of wrapping the counter.
  assign toggle = en && (div_cnt >= div);
  assign rise   = toggle && !cclock;
  assign fall   = toggle && cclock;

  // Half-period counter and cclock register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      cclock  <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      cclock  <= 1'b0;
    end else if (toggle) begin
      div_cnt <= '0;
      cclock  <= ~cclock;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tblink_rpc_cclock_sched.sv
// Controlled-clock scheduler: decodes host time commands, owns the
// HALTED/RUN/STOPPING state machine, the rising-edge counter and the
// one-shot timer, and drives the divider that generates cclock.
module tblink_rpc_cclock_sched
  import tblink_rpc_cmd_pkg::*;
#(
  parameter int COUNT_W = 64,
  parameter int DIV_W   = 32
) (
  input  logic               uclock,
  input  logic               reset,
  input  logic               cmd_put_i,
  output logic               cmd_get_o,
  input  logic [7:0]         cmd_op,
  input  logic [COUNT_W-1:0] cmd_params,
  output logic [COUNT_W-1:0] cmd_rsp,
  output logic [7:0]         cmd_rsp_sz,
  output logic               cclock,
  output logic [COUNT_W-1:0] cclock_count,
  output logic               running,
  output logic               hreq_o
);

  sched_state_e       state, state_n;
  logic               stop_timer, stop_timer_n;
  logic               hreq_n;
  logic               armed;
  logic [COUNT_W-1:0] target;
  logic [COUNT_W-1:0] count_inc;
  logic [DIV_W-1:0]   div;
  logic               rise, fall, clk_en;
  logic               cmd_valid;
  logic               do_get_time, do_set_timer, do_release, do_set_div, do_halt;
  logic               expire;

  assign cmd_valid    = (cmd_put_i != cmd_get_o);
  assign do_get_time  = cmd_valid && (cmd_op == CMD_GET_TIME);
  assign do_set_timer = cmd_valid && (cmd_op == CMD_SET_TIMER);
  assign do_release   = cmd_valid && (cmd_op == CMD_RELEASE);
  assign do_set_div   = cmd_valid && (cmd_op == CMD_SET_DIVISOR);
  assign do_halt      = cmd_valid && (cmd_op == CMD_HALT);

  assign count_inc = cclock_count + 1'b1;
  // Expiry compares against the timer as it stood before this cycle's
  // command, so a SetTimer landing on the incremented count waits a wrap.
  assign expire    = (state == ST_RUN) && rise && armed && (count_inc == target);
  assign clk_en    = (state != ST_HALTED);
  assign running   = clk_en;

  tblink_rpc_clkdiv #(
    .DIV_W (DIV_W)
  ) u_clkdiv (
    .clk    (uclock),
    .rst    (reset),
    .en     (clk_en),
    .div    (div),
    .cclock (cclock),
    .rise   (rise),
    .fall   (fall)
  );

  // Next-state logic; a timer stop raises hreq only once cclock is low.
  always_comb begin
    state_n      = state;
    stop_timer_n = stop_timer;
    hreq_n       = hreq_o;
    if (do_release) hreq_n = 1'b0;
    unique case (state)
      ST_HALTED: begin
        if (do_release) state_n = ST_RUN;
      end
      ST_RUN: begin
        if (expire) begin
          state_n      = ST_STOPPING;
          stop_timer_n = 1'b1;
        end else if (do_halt) begin
          state_n      = ST_STOPPING;
          stop_timer_n = 1'b0;
        end
      end
      ST_STOPPING: begin
        if (fall) begin
          state_n      = ST_HALTED;
          stop_timer_n = 1'b0;
          if (stop_timer) hreq_n = 1'b1;
        end
      end
      default: begin
        state_n      = ST_HALTED;
        stop_timer_n = 1'b0;
      end
    endcase
  end

  // State register, stop cause and host request level.
  always_ff @(posedge uclock or posedge reset) begin
    if (reset) begin
      state      <= ST_HALTED;
      stop_timer <= 1'b0;
      hreq_o     <= 1'b0;
    end else begin
      state      <= state_n;
      stop_timer <= stop_timer_n;
      hreq_o     <= hreq_n;
    end
  end

  // Rising-edge counter and one-shot timer; a SetTimer overrides expiry.
  always_ff @(posedge uclock or posedge reset) begin
    if (reset) begin
      cclock_count <= '0;
      armed        <= 1'b0;
      target       <= '0;
    end else begin
      if (rise) cclock_count <= count_inc;
      if (expire) armed <= 1'b0;
      if (do_set_timer) begin
        if (|cmd_params) begin
          target <= cclock_count + cmd_params;
          armed  <= 1'b1;
        end else begin
          armed  <= 1'b0;
        end
      end
    end
  end

  // Divisor register, applied to the divider from the next cycle on.
  always_ff @(posedge uclock or posedge reset) begin
    if (reset) begin
      div <= '0;
    end else if (do_set_div) begin
      div <= cmd_params[DIV_W-1:0];
    end
  end

  // Command completion: toggle get and present the response together.
  always_ff @(posedge uclock or posedge reset) begin
    if (reset) begin
      cmd_get_o  <= 1'b0;
      cmd_rsp    <= '0;
      cmd_rsp_sz <= RSP_SZ_NONE;
    end else if (cmd_valid) begin
      cmd_get_o <= ~cmd_get_o;
      if (do_get_time) begin
        cmd_rsp    <= cclock_count;
        cmd_rsp_sz <= RSP_SZ_TIME;
      end else begin
        cmd_rsp    <= '0;
        cmd_rsp_sz <= RSP_SZ_NONE;
      end
    end
  end

endmodule
